// File: rtl/lcd_text_buffer.sv
// lcd_text_buffer: character buffer for a ROWS x COLS text display.
// A display controller reads one character per cycle through a registered,
// read-first port. Writers can update the buffer in two ways: a random-access
// port (we/waddr/din) or a cursor port (put_*) that appends characters and
// handles newline. A clear request, and every reset, fills the whole buffer
// with spaces. The fill takes DEPTH cycles, and busy is high while it runs.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   lcd_index/lcd_char display read address / registered read data
//   we, waddr, din     random-access write (out-of-range addresses ignored)
//   put_valid/put_char/put_ready  cursor write handshake
//   clear, busy        clear-screen request / fill in progress
//   cursor             current cursor address
module lcd_text_buffer #(
  parameter int unsigned ROWS = 2,
  parameter int unsigned COLS = 16,
  parameter int unsigned CW   = 8,
  localparam int unsigned DEPTH = ROWS * COLS,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] lcd_index,
  output logic [CW-1:0] lcd_char,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [CW-1:0] din,
  input  logic          put_valid,
  input  logic [CW-1:0] put_char,
  output logic          put_ready,
  input  logic          clear,
  output logic          busy,
  output logic [AW-1:0] cursor
);

  localparam int unsigned CLW      = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [AW:0]    DEPTH_X  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]  LAST     = AW'(DEPTH - 1);
  localparam logic [CLW-1:0] COL_LAST = CLW'(COLS - 1);
  localparam logic [CW-1:0]  SPACE    = CW'(8'h20);
  localparam logic [CW-1:0]  NL       = CW'(8'h0A);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t         state;
  logic [AW-1:0]  fill;
  logic [AW-1:0]  cur_addr;
  logic [CLW-1:0] col;       // column of cur_addr, kept to avoid a divider
  logic [CW-1:0]  mem [DEPTH];

  logic           put_fire;
  logic           rd_in_range;
  logic           mem_we;
  logic [AW-1:0]  mem_addr;
  logic [CW-1:0]  mem_din;
  logic [AW-1:0]  cur_inc;
  logic [AW-1:0]  cur_nl;
  logic [CLW-1:0] col_inc;
  logic [AW:0]    nl_sum;

  assign busy        = (state == CLEAR);
  assign cursor      = cur_addr;
  // clear and random writes both take priority over the cursor port
  assign put_ready   = (state == IDLE) && !we && !clear;
  assign put_fire    = put_valid && put_ready;
  assign rd_in_range = (AW+1)'(lcd_index) < DEPTH_X;

  // Next cursor positions for a plain character and for a newline
  always_comb begin
    cur_inc = (cur_addr == LAST) ? '0 : cur_addr + 1'b1;
    col_inc = (col == COL_LAST) ? '0 : col + 1'b1;
    nl_sum  = (AW+1)'(cur_addr) + (AW+1)'(COLS) - (AW+1)'(col);
    cur_nl  = (nl_sum >= DEPTH_X) ? '0 : nl_sum[AW-1:0];
  end

  // Single write port arbitration: fill, then random write, then put
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (!rst) begin
      if (state == CLEAR) begin
        mem_we   = 1'b1;
        mem_addr = fill;
        mem_din  = SPACE;
      end else if (!clear) begin
        if (we) begin
          mem_we   = (AW+1)'(waddr) < DEPTH_X;
          mem_addr = waddr;
          mem_din  = din;
        end else if (put_fire && (put_char != NL)) begin
          mem_we   = 1'b1;
          mem_addr = cur_addr;
          mem_din  = put_char;
        end
      end
    end
  end

  // Storage has no reset; the post-reset fill initialises it
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end
  end

  // Control state, cursor and registered read port
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      fill     <= '0;
      cur_addr <= '0;
      col      <= '0;
      lcd_char <= SPACE;
    end else begin
      lcd_char <= rd_in_range ? mem[lcd_index] : SPACE;
      case (state)
        IDLE: begin
          if (clear) begin
            state <= CLEAR;
            fill  <= '0;
          end else if (put_fire) begin
            if (put_char == NL) begin
              cur_addr <= cur_nl;
              col      <= '0;
            end else begin
              cur_addr <= cur_inc;
              col      <= col_inc;
            end
          end
        end
        CLEAR: begin
          if (fill == LAST) begin
            state    <= IDLE;
            cur_addr <= '0;
            col      <= '0;
          end else begin
            fill <= fill + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Testbench for lcd_text_buffer: a 2x16 instance checked every cycle against
// a row/column text-screen model, plus a 3x10 instance for out-of-range
// addressing and cursor wrap on a non-power-of-two depth.
module tb_lcd_text_buffer;

  localparam int ROWS  = 2;
  localparam int COLS  = 16;
  localparam int DEPTH = ROWS * COLS;

  logic       clk;
  logic       rst;
  logic [4:0] lcd_index;
  logic [7:0] lcd_char;
  logic       we;
  logic [4:0] waddr;
  logic [7:0] din;
  logic       put_valid;
  logic [7:0] put_char;
  logic       put_ready;
  logic       clear;
  logic       busy;
  logic [4:0] cursor;

  logic [4:0] b_lcd_index;
  logic [7:0] b_lcd_char;
  logic       b_we;
  logic [4:0] b_waddr;
  logic [7:0] b_din;
  logic       b_put_valid;
  logic [7:0] b_put_char;
  logic       b_put_ready;
  logic       b_clear;
  logic       b_busy;
  logic [4:0] b_cursor;

  int total = 0;
  int bad   = 0;

  lcd_text_buffer #(.ROWS(2), .COLS(16), .CW(8)) dut (
    .clk(clk), .rst(rst), .lcd_index(lcd_index), .lcd_char(lcd_char),
    .we(we), .waddr(waddr), .din(din), .put_valid(put_valid),
    .put_char(put_char), .put_ready(put_ready), .clear(clear),
    .busy(busy), .cursor(cursor)
  );

  lcd_text_buffer #(.ROWS(3), .COLS(10), .CW(8)) dut_b (
    .clk(clk), .rst(rst), .lcd_index(b_lcd_index), .lcd_char(b_lcd_char),
    .we(b_we), .waddr(b_waddr), .din(b_din), .put_valid(b_put_valid),
    .put_char(b_put_char), .put_ready(b_put_ready), .clear(b_clear),
    .busy(b_busy), .cursor(b_cursor)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Screen model: text grid with row/col cursor and a count of fill cycles left
  logic [7:0] m_mem [DEPTH];
  bit         m_known [DEPTH];
  int         m_left = 0;
  int         m_row = 0;
  int         m_col = 0;
  logic [7:0] m_char = 8'h20;
  bit         m_char_known = 1'b0;
  bit         m_init = 1'b0;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_init       = 1'b1;
        m_left       = DEPTH;
        m_row        = 0;
        m_col        = 0;
        m_char       = 8'h20;
        m_char_known = 1'b1;
      end else if (m_init) begin
        if (int'(lcd_index) >= DEPTH) begin
          m_char       = 8'h20;
          m_char_known = 1'b1;
        end else begin
          m_char       = m_mem[lcd_index];
          m_char_known = m_known[lcd_index];
        end
        if (m_left > 0) begin
          m_mem[DEPTH - m_left]   = 8'h20;
          m_known[DEPTH - m_left] = 1'b1;
          m_left--;
          if (m_left == 0) begin
            m_row = 0;
            m_col = 0;
          end
        end else if (clear) begin
          m_left = DEPTH;
        end else if (we) begin
          if (int'(waddr) < DEPTH) begin
            m_mem[waddr]   = din;
            m_known[waddr] = 1'b1;
          end
        end else if (put_valid) begin
          if (put_char == 8'h0A) begin
            m_col = 0;
            m_row = (m_row + 1) % ROWS;
          end else begin
            m_mem[m_row * COLS + m_col]   = put_char;
            m_known[m_row * COLS + m_col] = 1'b1;
            m_col++;
            if (m_col == COLS) begin
              m_col = 0;
              m_row = (m_row + 1) % ROWS;
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        if (m_char_known) check("m_lcd_char", 32'(lcd_char), 32'(m_char));
        check("m_busy", 32'(busy), 32'(m_left > 0));
        check("m_cursor", 32'(cursor), 32'(m_row * COLS + m_col));
        check("m_put_ready", 32'(put_ready), 32'((m_left == 0) && !we && !clear));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic read_a(input logic [4:0] idx, output logic [7:0] d);
    lcd_index = idx;
    step();
    @(negedge clk);
    d = lcd_char;
    step();
  endtask

  task automatic read_b(input logic [4:0] idx, output logic [7:0] d);
    b_lcd_index = idx;
    step();
    @(negedge clk);
    d = b_lcd_char;
    step();
  endtask

  // Counts consecutive busy cycles; optionally pulses clear during the fill
  task automatic count_busy(input bit poke, output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      @(posedge clk);
      #2;
      clear = poke && (n == 5 || n == 9);
    end
    clear = 1'b0;
    step();
  endtask

  task automatic b_put(input logic [7:0] c);
    b_put_valid = 1'b1;
    b_put_char  = c;
    step();
    b_put_valid = 1'b0;
  endtask

  int         n;
  int         ns;
  logic [7:0] d;

  initial begin
    rst = 1'b1; lcd_index = '0; we = 1'b0; waddr = '0; din = '0;
    put_valid = 1'b0; put_char = '0; clear = 1'b0;
    b_lcd_index = '0; b_we = 1'b0; b_waddr = '0; b_din = '0;
    b_put_valid = 1'b0; b_put_char = '0; b_clear = 1'b0;

    // Reset and initial fill
    step();
    @(negedge clk);
    check("rst_lcd_char", 32'(lcd_char), 32'h20);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_cursor", 32'(cursor), 32'd0);
    check("rst_put_ready", 32'(put_ready), 32'd0);
    step();
    rst = 1'b0;
    count_busy(1'b0, n);
    check("rst_busy_len", 32'(n), 32'd32);
    ns = 0;
    for (int i = 0; i < DEPTH; i++) begin
      read_a(5'(i), d);
      if (d !== 8'h20) ns++;
    end
    check("rst_fill_spaces", 32'(ns), 32'd0);
    @(negedge clk);
    check("idle_cursor", 32'(cursor), 32'd0);
    check("idle_put_ready", 32'(put_ready), 32'd1);
    step();

    // Cursor writes "ABC"
    put_valid = 1'b1;
    put_char = 8'h41; step();
    put_char = 8'h42; step();
    put_char = 8'h43; step();
    put_valid = 1'b0;
    @(negedge clk);
    check("abc_cursor", 32'(cursor), 32'd3);
    step();
    read_a(5'd1, d);
    check("abc_read1", 32'(d), 32'h42);
    read_a(5'd2, d);
    check("abc_read2", 32'(d), 32'h43);

    // Newline, 17 chars across the end, then newlines wrapping rows
    put_valid = 1'b1; put_char = 8'h0A; step(); put_valid = 1'b0;
    @(negedge clk);
    check("nl_cursor", 32'(cursor), 32'd16);
    step();
    put_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      put_char = 8'(8'h61 + i);
      step();
    end
    put_valid = 1'b0;
    @(negedge clk);
    check("wrap_cursor", 32'(cursor), 32'd1);
    step();
    read_a(5'd0, d);
    check("wrap_mem0", 32'(d), 32'h71);
    read_a(5'd31, d);
    check("wrap_mem31", 32'(d), 32'h70);
    read_a(5'd16, d);
    check("wrap_mem16", 32'(d), 32'h61);
    put_valid = 1'b1; put_char = 8'h0A; step(); step(); put_valid = 1'b0;
    @(negedge clk);
    check("nl_last_row_wrap", 32'(cursor), 32'd0);
    step();

    // Random write priority over put, read-first on the same address
    lcd_index = 5'd5; we = 1'b1; waddr = 5'd5; din = 8'h5A;
    put_valid = 1'b1; put_char = 8'h44;
    @(negedge clk);
    check("prio_ready_low", 32'(put_ready), 32'd0);
    step();
    we = 1'b0;
    @(negedge clk);
    check("read_first_old", 32'(lcd_char), 32'h20);
    check("prio_ready_after", 32'(put_ready), 32'd1);
    step();
    put_valid = 1'b0;
    @(negedge clk);
    check("read_new", 32'(lcd_char), 32'h5A);
    check("prio_put_cursor", 32'(cursor), 32'd1);
    step();
    read_a(5'd0, d);
    check("prio_put_mem0", 32'(d), 32'h44);

    // Clear with a held put and clear pulses during the fill
    put_valid = 1'b1; put_char = 8'h51; clear = 1'b1;
    @(negedge clk);
    check("clear_drops_put", 32'(put_ready), 32'd0);
    step();
    clear = 1'b0;
    count_busy(1'b1, n);
    check("clear_busy_len", 32'(n), 32'd32);
    put_valid = 1'b0;
    @(negedge clk);
    check("held_put_cursor", 32'(cursor), 32'd1);
    step();
    read_a(5'd0, d);
    check("held_put_mem0", 32'(d), 32'h51);
    ns = 0;
    for (int i = 1; i < DEPTH; i++) begin
      read_a(5'(i), d);
      if (d !== 8'h20) ns++;
    end
    check("clear_spaces", 32'(ns), 32'd0);

    // Reset in the middle of a fill, with a put pending
    clear = 1'b1; step(); clear = 1'b0;
    repeat (10) step();
    rst = 1'b1; put_valid = 1'b1; put_char = 8'h52;
    step();
    rst = 1'b0; put_valid = 1'b0;
    count_busy(1'b0, n);
    check("rst_mid_clear_len", 32'(n), 32'd32);
    @(negedge clk);
    check("rst_mid_cursor", 32'(cursor), 32'd0);
    step();

    // 3x10 instance: out-of-range read/write and cursor wrap at depth 30
    read_b(5'd31, d);
    check("b_oor_read", 32'(d), 32'h20);
    b_we = 1'b1; b_waddr = 5'd30; b_din = 8'h51; step(); b_we = 1'b0;
    read_b(5'd0, d);
    check("b_oor_write_ignored", 32'(d), 32'h20);
    b_we = 1'b1; b_waddr = 5'd29; b_din = 8'h57; step(); b_we = 1'b0;
    read_b(5'd29, d);
    check("b_write29", 32'(d), 32'h57);
    b_put(8'h0A);
    @(negedge clk);
    check("b_nl1", 32'(b_cursor), 32'd10);
    step();
    b_put(8'h0A);
    b_put(8'h0A);
    @(negedge clk);
    check("b_nl_wrap", 32'(b_cursor), 32'd0);
    step();
    b_put(8'h0A);
    b_put(8'h0A);
    for (int i = 0; i < 10; i++) b_put(8'(8'h30 + i));
    @(negedge clk);
    check("b_char_wrap", 32'(b_cursor), 32'd0);
    check("b_busy", 32'(b_busy), 32'd0);
    step();
    read_b(5'd29, d);
    check("b_mem29", 32'(d), 32'h39);
    read_b(5'd20, d);
    check("b_mem20", 32'(d), 32'h30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
